// File: rtl/lii_msg_tx.sv
// lii_msg_tx - LII message transmitter.
//
// Turns one command descriptor plus a raw payload word stream into a framed
// LII packet. Every beat carries this node's source ID, the latched
// destination and type, per-byte keep/strb, and a last flag on the final beat.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cmd_dst/type/len    : command descriptor (len in bytes)
//   cmd_valid/cmd_ready : command handshake
//   p_data              : payload word, byte 0 in p_data[7:0]
//   p_valid/p_ready     : payload handshake
//   m_data/keep/strb/last/src/dst/type, m_valid/m_ready : LII beat out
//   busy                : message in progress or output register occupied
//   done                : one-cycle pulse, registered, in the cycle after the
//                         final payload word of a message is accepted
//   err                 : one-cycle pulse, registered, in the cycle after a
//                         zero-length command is accepted
module lii_msg_tx #(
  parameter int          DW     = 256,
  parameter int          SRC_W  = 8,
  parameter int          DST_W  = 8,
  parameter int          TYPE_W = 2,
  parameter int          LEN_W  = 16,
  parameter int unsigned SRC_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DST_W-1:0]  cmd_dst,
  input  logic [TYPE_W-1:0] cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     p_data,
  input  logic              p_valid,
  output logic              p_ready,
  output logic [DW-1:0]     m_data,
  output logic [DW/8-1:0]   m_keep,
  output logic [DW/8-1:0]   m_strb,
  output logic              m_last,
  output logic [SRC_W-1:0]  m_src,
  output logic [DST_W-1:0]  m_dst,
  output logic [TYPE_W-1:0] m_type,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BPB     = DW / 8;
  localparam int LOG2BPB = $clog2(BPB);
  // With one byte per beat there is no tail field; the 1-bit tail register
  // then always holds zero.
  localparam int TAIL_W  = (LOG2BPB > 0) ? LOG2BPB : 1;
  // One extra bit so that ceil((2^LEN_W - 1) / BPB) fits.
  localparam int BL_W    = LEN_W - LOG2BPB + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BL_W-1:0]     beats_left_q, beats_left_d;
  logic [TAIL_W-1:0]   tail_q, tail_d;
  logic [DST_W-1:0]    dst_q, dst_d;
  logic [TYPE_W-1:0]   type_q, type_d;

  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic [BPB-1:0]      m_keep_q, m_keep_d;
  logic [DST_W-1:0]    m_dst_q, m_dst_d;
  logic [TYPE_W-1:0]   m_type_q, m_type_d;

  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cmd_fire;
  logic                p_fire;
  logic [LEN_W:0]      len_round;
  logic [BL_W-1:0]     cmd_beats;
  logic [TAIL_W-1:0]   cmd_tail;

  // Byte-enable mask for the final beat: low `tail` bytes, or a full beat
  // when the length is a whole number of beats.
  function automatic logic [BPB-1:0] last_keep(input logic [TAIL_W-1:0] tail);
    logic [BPB-1:0] k;
    for (int i = 0; i < BPB; i++) begin
      k[i] = (tail == '0) || (i < int'(tail));
    end
    return k;
  endfunction

  // ceil(len / BPB) computed one bit wider than the length so the rounding
  // add cannot wrap for the largest length.
  assign len_round = {1'b0, cmd_len} + (LEN_W+1)'(BPB - 1);
  assign cmd_beats = BL_W'(len_round >> LOG2BPB);
  assign cmd_tail  = TAIL_W'(cmd_len & LEN_W'(BPB - 1));

  assign cmd_fire = cmd_valid && cmd_ready;
  assign p_fire   = p_valid && p_ready;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    tail_d       = tail_q;
    dst_d        = dst_q;
    type_d       = type_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_dst_d      = m_dst_q;
    m_type_d     = m_type_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cmd_ready    = 1'b0;
    p_ready      = 1'b0;

    // Output register drains; a load below in the same cycle overrides this.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Gated by rst so nothing is offered while reset is held.
        cmd_ready = !rst;
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            err_d = 1'b1;
          end else begin
            dst_d        = cmd_dst;
            type_d       = cmd_type;
            beats_left_d = cmd_beats;
            tail_d       = cmd_tail;
            state_d      = SEND;
          end
        end
      end
      SEND: begin
        // Single-stage output register: accept when empty or draining now.
        p_ready = !rst && (!m_valid_q || m_ready);
        if (p_fire) begin
          m_valid_d    = 1'b1;
          m_data_d     = p_data;
          m_dst_d      = dst_q;
          m_type_d     = type_q;
          m_last_d     = (beats_left_q == BL_W'(1));
          m_keep_d     = (beats_left_q == BL_W'(1)) ? last_keep(tail_q) : '1;
          beats_left_d = beats_left_q - BL_W'(1);
          if (beats_left_q == BL_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      tail_q       <= '0;
      dst_q        <= '0;
      type_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_dst_q      <= '0;
      m_type_q     <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      tail_q       <= tail_d;
      dst_q        <= dst_d;
      type_q       <= type_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_dst_q      <= m_dst_d;
      m_type_q     <= m_type_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_strb  = m_keep_q;
  assign m_src   = SRC_W'(SRC_ID);
  assign m_dst   = m_dst_q;
  assign m_type  = m_type_q;
  assign busy    = (state_q == SEND) || m_valid_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_lii_msg_tx.sv
// Testbench for lii_msg_tx (DW=256, SRC_ID=5). A reference model expands
// each command into the list of beats it must produce; a monitor compares
// every accepted beat against that list and checks hold-while-stalled.
module tb_lii_msg_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   cmd_dst;
  logic [1:0]   cmd_type;
  logic [15:0]  cmd_len;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] p_data;
  logic         p_valid;
  logic         p_ready;
  logic [255:0] m_data;
  logic [31:0]  m_keep;
  logic [31:0]  m_strb;
  logic         m_last;
  logic [7:0]   m_src;
  logic [7:0]   m_dst;
  logic [1:0]   m_type;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
  logic         done;
  logic         err;

  lii_msg_tx #(.DW(256), .SRC_W(8), .DST_W(8), .TYPE_W(2), .LEN_W(16), .SRC_ID(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_dst(cmd_dst), .cmd_type(cmd_type), .cmd_len(cmd_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready),
    .m_data(m_data), .m_keep(m_keep), .m_strb(m_strb), .m_last(m_last),
    .m_src(m_src), .m_dst(m_dst), .m_type(m_type),
    .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [7:0]   dst;
    logic [1:0]   typ;
  } beat_t;

  beat_t        exp_q[$];
  logic [255:0] pay_q[$];
  int           fire_t[$];

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  beats_seen = 0;
  int  pay_fires = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  mr_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit  pay_gap = 0;
  bit  p_fire_seen = 0;
  bit  prev_stall = 0;
  logic [255:0] snap_data;
  logic [83:0]  snap_ctl;
  beat_t        mon_b;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a len-byte message is ceil(len/32) beats; beat i carries
  // min(32, len-32*i) valid bytes.
  task automatic push_msg(input logic [7:0] dst, input logic [1:0] typ, input int len);
    int nb;
    nb = (len + 31) / 32;
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      int bytes;
      bytes = len - 32 * i;
      if (bytes > 32) bytes = 32;
      for (int j = 0; j < 8; j++) b.data[32*j +: 32] = $urandom();
      b.keep = (bytes == 32) ? 32'hFFFF_FFFF : ((32'h1 << bytes) - 32'h1);
      b.last = (i == nb - 1);
      b.dst  = dst;
      b.typ  = typ;
      exp_q.push_back(b);
      pay_q.push_back(b.data);
    end
  endtask

  task automatic send_cmd(input logic [7:0] dst, input logic [1:0] typ, input int len);
    int c;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_dst   = dst;
    cmd_type  = typ;
    cmd_len   = 16'(len);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!cmd_ready && c < 300);
    if (!cmd_ready) chk("cmd_accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic msg(input logic [7:0] dst, input logic [1:0] typ, input int len);
    push_msg(dst, typ, len);
    send_cmd(dst, typ, len);
  endtask

  task automatic wait_idle(input int max_cyc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((exp_q.size() != 0 || busy) && c <= max_cyc);
    chk("drain_timeout", c <= max_cyc, 1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Payload source: presents the head of pay_q, pops it once accepted.
  initial begin
    p_valid = 1'b0;
    p_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (p_fire_seen && pay_q.size() > 0) pay_q.delete(0);
      if (!rst && pay_q.size() > 0 && (!pay_gap || $urandom_range(0, 3) != 0)) begin
        p_valid = 1'b1;
        p_data  = pay_q[0];
      end else begin
        p_valid = 1'b0;
        p_data  = '0;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    p_fire_seen = !rst && p_valid && p_ready;
    if (!rst) begin
      if (m_valid && !m_ready) chk("p_ready_while_stalled", p_ready, 1'b0);
      if (prev_stall) begin
        chk("stall_hold_data", m_data, snap_data);
        chk("stall_hold_ctl", {m_valid, m_keep, m_strb, m_last, m_src, m_dst, m_type}, snap_ctl);
      end
      if (m_valid && m_ready) begin
        beats_seen++;
        fire_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          mon_b = exp_q.pop_front();
          chk("m_data", m_data, mon_b.data);
          chk("m_keep", m_keep, mon_b.keep);
          chk("m_strb", m_strb, mon_b.keep);
          chk("m_last", m_last, mon_b.last);
          chk("m_src", m_src, 8'd5);
          chk("m_dst", m_dst, mon_b.dst);
          chk("m_type", m_type, mon_b.typ);
        end
      end
      if (p_valid && p_ready) pay_fires++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done || err) chk("done_err_exclusive", done && err, 1'b0);
    end
    prev_stall = !rst && m_valid && !m_ready;
    snap_data  = m_data;
    snap_ctl   = {m_valid, m_keep, m_strb, m_last, m_src, m_dst, m_type};
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_beats, base_done, base_err, base_pay, c;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dst   = '0;
    cmd_type  = '0;
    cmd_len   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, 256'h0);
    chk("rst_m_keep", m_keep, 32'h0);
    chk("rst_m_strb", m_strb, 32'h0);
    chk("rst_m_dst", m_dst, 8'h0);
    chk("rst_m_type", m_type, 2'h0);
    chk("rst_m_src", m_src, 8'd5);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_p_ready", p_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Single full beat
    base_done = done_cnt;
    msg(8'd3, 2'd1, 32);
    @(negedge clk);
    chk("busy_after_cmd", busy, 1'b1);
    wait_idle(200);
    chk("single_done_count", done_cnt - base_done, 1);

    // Three beats with a partial tail
    base_beats = beats_seen;
    msg(8'd7, 2'd2, 70);
    wait_idle(200);
    chk("len70_beats", beats_seen - base_beats, 3);

    // Alternating backpressure
    mr_mode = 1;
    base_beats = beats_seen;
    msg(8'd9, 2'd3, 96);
    wait_idle(200);
    chk("len96_beats", beats_seen - base_beats, 3);
    mr_mode = 0;

    // Zero length: err only, nothing consumed
    base_err = err_cnt; base_beats = beats_seen; base_pay = pay_fires; base_done = done_cnt;
    pay_q.push_back({8{32'hDEAD_BEEF}});
    send_cmd(8'd1, 2'd0, 0);
    @(negedge clk);
    chk("len0_cmd_ready_next", cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("len0_err_count", err_cnt - base_err, 1);
    chk("len0_no_beats", beats_seen - base_beats, 0);
    chk("len0_no_payload", pay_fires - base_pay, 0);
    chk("len0_no_done", done_cnt - base_done, 0);
    chk("len0_m_valid", m_valid, 1'b0);
    pay_q.delete();
    repeat (2) @(negedge clk);

    // Back-to-back commands, payload always available
    fire_t.delete();
    push_msg(8'd4, 2'd1, 64);
    push_msg(8'd6, 2'd2, 1);
    send_cmd(8'd4, 2'd1, 64);
    send_cmd(8'd6, 2'd2, 1);
    wait_idle(200);
    chk("b2b_beats", fire_t.size(), 3);
    if (fire_t.size() == 3) begin
      chk("b2b_intra_gap", fire_t[1] - fire_t[0], 1);
      chk("b2b_inter_gap_le2", (fire_t[2] - fire_t[1]) <= 2, 1'b1);
    end

    // Randomized lengths, backpressure and payload gaps
    mr_mode = 2; pay_gap = 1;
    base_done = done_cnt;
    for (int k = 0; k < 10; k++) begin
      int len;
      case (k)
        0: len = 31;
        1: len = 33;
        2: len = 63;
        default: len = $urandom_range(1, 300);
      endcase
      msg(8'($urandom()), 2'($urandom()), len);
      wait_idle(2000);
    end
    chk("random_done_count", done_cnt - base_done, 10);
    mr_mode = 0; pay_gap = 0;

    // Maximum length: 2048 beats, final keep 0x7FFFFFFF
    base_beats = beats_seen;
    msg(8'hAA, 2'd3, 65535);
    wait_idle(3000);
    chk("maxlen_beats", beats_seen - base_beats, 2048);

    // Reset during beat 2 of a 4-beat message
    base_beats = beats_seen;
    msg(8'd2, 2'd1, 128);
    c = 0;
    while (beats_seen < base_beats + 1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("rst_mid_reach_beat", beats_seen >= base_beats + 1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_m_valid", m_valid, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    pay_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_ready_after", cmd_ready, 1'b1);
    chk("rst_mid_m_valid_after", m_valid, 1'b0);
    base_beats = beats_seen;
    msg(8'd3, 2'd1, 32);
    wait_idle(200);
    chk("after_rst_beats", beats_seen - base_beats, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
